// File: rtl/paridade_pkg.sv
// Shared constants for the paridade parity generator/checker.
// Optional error counter is enabled by defining PARIDADE_ERRCNT_EN.
package paridade_pkg;

    localparam int PAR_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_ZERO = 16'h0000;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE  = 16'h0001;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/paridade_xor.sv
// Combinational WIDTH-bit XOR reduction, inverted when odd parity is selected.
module paridade_xor
    import paridade_pkg::*;
#(
    parameter int   WIDTH = PAR_WIDTH_DEF,
    parameter logic ODD   = PAR_EVEN
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             par_o
);

    assign par_o = (^data_i) ^ ODD;

endmodule

// File: rtl/paridade_core.sv
// Parity generator/checker: combinational parity, registered copy with strobe,
// mismatch check with sticky flag; PARIDADE_ERRCNT_EN adds a saturating err_cnt.
module paridade_core
    import paridade_pkg::*;
#(
    parameter int   WIDTH = PAR_WIDTH_DEF,
    parameter logic ODD   = PAR_EVEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             chk_en,
    input  logic             par_in,
    input  logic             clr,
    output logic             out,
    output logic             par_q,
    output logic             par_vld,
    output logic             err,
    output logic             err_sticky
`ifdef PARIDADE_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic par_s;
    logic par_bit_d, par_bit_q;
    logic vld_d, vld_q;
    logic err_d, err_q;
    logic sticky_d, sticky_q;

    paridade_xor #(
        .WIDTH (WIDTH),
        .ODD   (ODD)
    ) u_xor (
        .data_i (in),
        .par_o  (par_s)
    );

    assign out = par_s;

    // Next-state for the registered parity, strobe, mismatch and sticky flag.
    always_comb begin
        par_bit_d = par_bit_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        sticky_d  = sticky_q;
        if (in_valid) begin
            par_bit_d = par_s;
            vld_d     = 1'b1;
            err_d     = chk_en & (par_s != par_in);
        end else begin
            par_bit_d = par_bit_q;
            vld_d     = 1'b0;
            err_d     = 1'b0;
        end
        // A new error beats a coincident clear.
        if (err_d) begin
            sticky_d = 1'b1;
        end else if (clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers for the parity path and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q <= 1'b0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
        end
    end

    assign par_q      = par_bit_q;
    assign par_vld    = vld_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

`ifdef PARIDADE_ERRCNT_EN
    logic [ERR_CNT_W-1:0] cnt_d, cnt_q;

    // Saturating error counter; clear with a coincident error restarts at one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            if (err_d) begin
                cnt_d = ERR_CNT_ONE;
            end else begin
                cnt_d = ERR_CNT_ZERO;
            end
        end else if (err_d && (cnt_q != ERR_CNT_MAX)) begin
            cnt_d = cnt_q + ERR_CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ERR_CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_paridade_core.sv
// Self-checking bench for paridade_core (default build and PARIDADE_ERRCNT_EN).
module tb_paridade_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_s;
    logic       in_valid, chk_en, par_in, clr;
    logic       out, par_q, par_vld, err, err_sticky;
    logic       w1_out, w1_par_q, w1_par_vld, w1_err, w1_err_sticky;
`ifdef PARIDADE_ERRCNT_EN
    logic [15:0] err_cnt, w1_err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_par, m_vld, m_err, m_sticky;
    int unsigned m_cnt;

    paridade_core #(.WIDTH(8), .ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_s), .in_valid(in_valid), .chk_en(chk_en),
        .par_in(par_in), .clr(clr), .out(out), .par_q(par_q), .par_vld(par_vld),
        .err(err), .err_sticky(err_sticky)
`ifdef PARIDADE_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    paridade_core #(.WIDTH(1), .ODD(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in(in_s[0:0]), .in_valid(in_valid), .chk_en(chk_en),
        .par_in(par_in), .clr(clr), .out(w1_out), .par_q(w1_par_q), .par_vld(w1_par_vld),
        .err(w1_err), .err_sticky(w1_err_sticky)
`ifdef PARIDADE_ERRCNT_EN
        , .err_cnt(w1_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic model_reset();
        m_par = 1'b0; m_vld = 1'b0; m_err = 1'b0; m_sticky = 1'b0; m_cnt = 0;
    endtask

    // Apply one cycle of inputs, advance the model at the edge, return #1 after it.
    task automatic drive(input logic [7:0] d, input logic v, input logic c,
                         input logic p, input logic k);
        logic pb;
        in_s = d; in_valid = v; chk_en = c; par_in = p; clr = k;
        @(posedge clk);
        pb = ref_par(d);
        if (v) begin
            m_par = pb; m_vld = 1'b1; m_err = c && (pb != p);
        end else begin
            m_vld = 1'b0; m_err = 1'b0;
        end
        if (k) begin
            m_sticky = m_err;
            m_cnt    = m_err ? 1 : 0;
        end else begin
            m_sticky = m_sticky | m_err;
            if (m_err && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        #1;
        in_valid = 1'b0; chk_en = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_s = 8'h01; in_valid = 1'b0; chk_en = 1'b0; par_in = 1'b0; clr = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({par_q, par_vld, err, err_sticky} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_regs: got %b expected 0000", {par_q, par_vld, err, err_sticky});
        end
        checks++;
        if (out !== 1'b1) begin
            failures++;
            $display("FAIL reset_out: got %b expected 1", out);
        end
`ifdef PARIDADE_ERRCNT_EN
        checks++;
        if (err_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL reset_cnt: got %h expected 0000", err_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb();
        logic [7:0] vec [10];
        logic       exp [10];
        logic [7:0] r;
        vec = '{8'h00, 8'h01, 8'h82, 8'h03, 8'hAA, 8'h2A, 8'h71, 8'hE3, 8'h8A, 8'hFF};
        exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            in_s = vec[i];
            #10;
            checks++;
            if (out !== exp[i]) begin
                failures++;
                $display("FAIL comb_sweep in=%h: got %b expected %b", vec[i], out, exp[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            r = 8'($urandom);
            in_s = r;
            #3;
            checks++;
            if (out !== ref_par(r) || w1_out !== ~r[0]) begin
                failures++;
                $display("FAIL comb_rand in=%h: got %b/%b expected %b/%b",
                         r, out, w1_out, ref_par(r), ~r[0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_registered();
        drive(8'h2A, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (par_vld !== 1'b1 || par_q !== 1'b1) begin
            failures++;
            $display("FAIL reg_path: got vld=%b q=%b expected vld=1 q=1", par_vld, par_q);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (par_vld !== 1'b0 || par_q !== 1'b1) begin
            failures++;
            $display("FAIL reg_hold: got vld=%b q=%b expected vld=0 q=1", par_vld, par_q);
        end
    endtask

    task automatic test_check();
        drive(8'hE3, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1 || err_sticky !== 1'b1 || par_vld !== 1'b1) begin
            failures++;
            $display("FAIL chk_mismatch: got err=%b st=%b vld=%b expected 1 1 1", err, err_sticky, par_vld);
        end
        drive(8'h8A, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b0 || err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL chk_match: got err=%b st=%b expected 0 1", err, err_sticky);
        end
        drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL chk_disabled: got err=%b expected 0", err);
        end
    endtask

    task automatic test_clear();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: got %b expected 0", err_sticky);
        end
        drive(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (err_sticky !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL clr_collision: got st=%b err=%b expected 1 1", err_sticky, err);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom), 1'($urandom_range(0, 15) == 0));
            checks++;
            if ({par_q, par_vld, err, err_sticky} !== {m_par, m_vld, m_err, m_sticky}) begin
                failures++;
                $display("FAIL b2b cycle %0d: got %b expected %b", i,
                         {par_q, par_vld, err, err_sticky}, {m_par, m_vld, m_err, m_sticky});
            end
`ifdef PARIDADE_ERRCNT_EN
            checks++;
            if (err_cnt !== 16'(m_cnt)) begin
                failures++;
                $display("FAIL b2b_cnt cycle %0d: got %0d expected %0d", i, err_cnt, m_cnt);
            end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        drive(8'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({par_q, par_vld, err, err_sticky} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_regs: got %b expected 0000", {par_q, par_vld, err, err_sticky});
        end
        in_s = 8'hE3;
        #1;
        checks++;
        if (out !== 1'b1) begin
            failures++;
            $display("FAIL midrst_out: got %b expected 1", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h71, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({par_q, par_vld, err, err_sticky} !== 4'b0111) begin
            failures++;
            $display("FAIL post_rst_word: got %b expected 0111", {par_q, par_vld, err, err_sticky});
        end
    endtask

`ifdef PARIDADE_ERRCNT_EN
    task automatic test_errcnt();
        logic [7:0] d;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            drive(d, 1'b1, 1'b1, ~ref_par(d), 1'b0);
        end
        checks++;
        if (err_cnt !== 16'd3) begin
            failures++;
            $display("FAIL cnt_three: got %0d expected 3", err_cnt);
        end
        for (int i = 0; i < 65540; i++) begin
            drive(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_saturate: got %h expected FFFF", err_cnt);
        end
        drive(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL cnt_clr_collision: got %0d expected 1", err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_comb();
        test_registered();
        test_check();
        test_clear();
        test_back_to_back();
        test_reset_midstream();
`ifdef PARIDADE_ERRCNT_EN
        test_errcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
